// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared definitions for the register-file writeback path.
//               This package holds the register address width, the register
//               count, the default data width, and the writeback request
//               bundle.
//               reg_onehot() returns a decoded register mask. Bit 0 of that
//               mask is always cleared because x0 is never tracked.
// Revision    : 1.0  initial release
// ============================================================================
package rv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;

  // One writeback requester as seen by the controller.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // Decoded register mask. x0 is hard-wired, so its bit is never produced.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] mask;
    mask      = '0;
    mask[addr] = 1'b1;
    mask[0]   = 1'b0;
    return mask;
  endfunction

endpackage : rv_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Two-input round-robin arbiter with a combinational grant.
//               A lone request is granted in the same cycle. When both inputs
//               request, the input that was not granted last wins. The
//               pointer moves only when a grant is issued, and it moves away
//               from the winner. The grant is forced low while reset is held.
// Ports       : clock    - rising-edge clock
//               reset_n  - asynchronous active-low reset; the pointer
//                          favours req[0] after reset
//               req[1:0] - request lines
//               gnt[1:0] - one-hot (or zero) grant
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 0: req[0] wins a tie, 1: req[1] wins a tie.
  logic r_prio_1;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (reset_n) begin
      case (req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_prio_1 ? 2'b10 : 2'b01;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign gnt = w_gnt;

  // A grant is always a completed handshake, because ready is the grant.
  // For that reason the pointer only needs to look at gnt.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prio_1 <= 1'b0;
    end else if (w_gnt[0]) begin
      r_prio_1 <= 1'b1;
    end else if (w_gnt[1]) begin
      r_prio_1 <= 1'b0;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rf_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_ctrl
// Description : Register-file writeback controller with an issue scoreboard.
//               - Issue side:
//                   - issue_hazard blocks an instruction when any of its
//                     registers (rs1, rs2 or rd) has a pending write.
//                   - An accepted issue marks its rd as busy.
//               - Writeback side:
//                   - Two requesters (wb0 = ALU, wb1 = load unit) are
//                     arbitrated round-robin.
//                   - The winner is registered once and presented on the
//                     register-file write port in the following cycle.
//                   - The busy bit for that register clears on the same edge
//                     where the register file commits the write.
//                   - If a new issue targets the same register on that edge,
//                     the busy bit stays set (set wins).
// Ports       : clock, reset_n                  - clock, async active-low reset
//               issue_valid/rd/rs1/rs2          - issuing instruction
//               issue_hazard                    - issue blocked this cycle
//               wb0_valid/ready/rd/data         - writeback requester 0
//               wb1_valid/ready/rd/data         - writeback requester 1
//               write_enable/rd_address/rd_data - register-file write port
//               busy[31:0]                      - pending-write scoreboard
// Note        : XLEN must equal rv_pkg::XLEN. The writeback bundle carries
//               the package data width.
// Revision    : 1.0  initial release
// ============================================================================
module rf_wb_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic                           clock,
  input  logic                           reset_n,

  input  logic                           issue_valid,
  input  logic [rv_pkg::REG_ADDR_W-1:0]  issue_rd,
  input  logic [rv_pkg::REG_ADDR_W-1:0]  issue_rs1,
  input  logic [rv_pkg::REG_ADDR_W-1:0]  issue_rs2,
  output logic                           issue_hazard,

  input  logic                           wb0_valid,
  output logic                           wb0_ready,
  input  logic [rv_pkg::REG_ADDR_W-1:0]  wb0_rd,
  input  logic [XLEN-1:0]                wb0_data,

  input  logic                           wb1_valid,
  output logic                           wb1_ready,
  input  logic [rv_pkg::REG_ADDR_W-1:0]  wb1_rd,
  input  logic [XLEN-1:0]                wb1_data,

  output logic                           write_enable,
  output logic [rv_pkg::REG_ADDR_W-1:0]  rd_address,
  output logic [XLEN-1:0]                rd_data,

  output logic [rv_pkg::NUM_REGS-1:0]    busy
);

  // --------------------------------------------------------------------------
  // Writeback arbitration
  // --------------------------------------------------------------------------
  wb_req_t    w_wb0;
  wb_req_t    w_wb1;
  wb_req_t    w_win;
  logic [1:0] w_gnt;
  logic       w_handshake;

  assign w_wb0 = '{valid: wb0_valid, rd: wb0_rd, data: wb0_data};
  assign w_wb1 = '{valid: wb1_valid, rd: wb1_rd, data: wb1_data};

  rr_arbiter u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({w_wb1.valid, w_wb0.valid}),
    .gnt     (w_gnt)
  );

  assign wb0_ready   = w_gnt[0];
  assign wb1_ready   = w_gnt[1];
  assign w_handshake = |w_gnt;
  assign w_win       = w_gnt[1] ? w_wb1 : w_wb0;

  // --------------------------------------------------------------------------
  // Register-file write port
  //   A handshake is captured once here, so the write pulse lasts a single
  //   cycle. A write to x0 is consumed but never enables the port.
  // --------------------------------------------------------------------------
  logic                  r_write_enable;
  logic [REG_ADDR_W-1:0] r_rd_address;
  logic [XLEN-1:0]       r_rd_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_write_enable <= 1'b0;
      r_rd_address   <= '0;
      r_rd_data      <= '0;
    end else begin
      r_write_enable <= w_handshake && (w_win.rd != '0);
      if (w_handshake) begin
        r_rd_address <= w_win.rd;
        r_rd_data    <= w_win.data;
      end
    end
  end

  assign write_enable = r_write_enable;
  assign rd_address   = r_rd_address;
  assign rd_data      = r_rd_data;

  // --------------------------------------------------------------------------
  // Issue hazard and scoreboard
  // --------------------------------------------------------------------------
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_hazard;
  logic                w_issue_accept;

  // busy[0] is never set, so x0 operands cannot create a hazard.
  assign w_hazard = reset_n & issue_valid &
                    (r_busy[issue_rs1] | r_busy[issue_rs2] | r_busy[issue_rd]);

  assign w_issue_accept = reset_n & issue_valid & ~w_hazard;

  // The clear is applied first and the set after it, so the set wins when
  // both hit the same register on the same edge.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_write_enable) begin
      w_busy_nxt = w_busy_nxt & ~reg_onehot(r_rd_address);
    end
    if (w_issue_accept) begin
      w_busy_nxt = w_busy_nxt | reg_onehot(issue_rd);
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign issue_hazard = w_hazard;
  assign busy         = r_busy;

endmodule : rf_wb_ctrl
`default_nettype wire

// File: tb/tb_rf_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_ctrl
// Description : Directed self-checking bench for rf_wb_ctrl.
//               Inputs change 1 ns after a rising edge. Outputs are checked
//               in one of two places:
//                 - registered outputs, 1 ns after an edge;
//                 - combinational outputs, 1 ns after the inputs change.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rf_wb_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_hazard;
  logic        wb0_valid, wb0_ready;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic        wb1_valid, wb1_ready;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  logic        write_enable;
  logic [4:0]  rd_address;
  logic [31:0] rd_data;
  logic [31:0] busy;

  int n_vec = 0;
  int n_err = 0;

  rf_wb_ctrl #(.XLEN(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_hazard (issue_hazard),
    .wb0_valid    (wb0_valid),
    .wb0_ready    (wb0_ready),
    .wb0_rd       (wb0_rd),
    .wb0_data     (wb0_data),
    .wb1_valid    (wb1_valid),
    .wb1_ready    (wb1_ready),
    .wb1_rd       (wb1_rd),
    .wb1_data     (wb1_data),
    .write_enable (write_enable),
    .rd_address   (rd_address),
    .rd_data      (rd_data),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    issue_valid = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    wb0_valid   = 1'b0; wb0_rd = 5'd0; wb0_data = 32'h0;
    wb1_valid   = 1'b0; wb1_rd = 5'd0; wb1_data = 32'h0;
    tick(); tick();

    // Reset state: requests are present but nothing may be granted.
    wb0_valid = 1'b1; wb1_valid = 1'b1; issue_valid = 1'b1; issue_rd = 5'd5;
    #1;
    chk("rst_busy",   busy,         32'h0);
    chk("rst_we",     write_enable, 32'h0);
    chk("rst_addr",   rd_address,   32'h0);
    chk("rst_data",   rd_data,      32'h0);
    chk("rst_ready0", wb0_ready,    32'h0);
    chk("rst_ready1", wb1_ready,    32'h0);
    chk("rst_hazard", issue_hazard, 32'h0);
    wb0_valid = 1'b0; wb1_valid = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0;
    reset_n = 1'b1;
    tick();

    // Contention right after reset: wb0, wb1, wb0, wb1, one write per cycle.
    wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'h0000_00A0;
    wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'h0000_00B0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_ready0", wb0_ready, (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_ready1", wb1_ready, (k % 2 == 1) ? 32'h1 : 32'h0);
      tick();
      chk("rr_we",   write_enable, 32'h1);
      chk("rr_addr", rd_address,   (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_data", rd_data,      (k % 2 == 0) ? 32'hA0 : 32'hB0);
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    tick();
    chk("rr_we_idle", write_enable, 32'h0);
    chk("rr_busy",    busy,         32'h0);

    // Issue x5, then write back x5.
    issue_valid = 1'b1; issue_rd = 5'd5; issue_rs1 = 5'd1; issue_rs2 = 5'd2;
    #1;
    chk("i5_hazard", issue_hazard, 32'h0);
    tick();
    issue_valid = 1'b0;
    chk("i5_busy_set", busy, 32'h0000_0020);
    wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEAD_BEEF;
    #1;
    chk("w5_ready0", wb0_ready, 32'h1);
    chk("w5_ready1", wb1_ready, 32'h0);
    tick();
    wb0_valid = 1'b0;
    chk("w5_we",        write_enable, 32'h1);
    chk("w5_addr",      rd_address,   32'd5);
    chk("w5_data",      rd_data,      32'hDEAD_BEEF);
    chk("w5_busy_held", busy,         32'h0000_0020);
    tick();
    chk("w5_we_off",  write_enable, 32'h0);
    chk("w5_busy_clr", busy,        32'h0);

    // RAW hazard on x3: the issue is held until the x3 write commits.
    issue_valid = 1'b1; issue_rd = 5'd3; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    tick();
    chk("i3_busy", busy, 32'h0000_0008);
    issue_rd = 5'd9; issue_rs1 = 5'd3; issue_rs2 = 5'd0;
    #1;
    chk("raw_hazard", issue_hazard, 32'h1);
    tick();
    chk("raw_busy_unch", busy, 32'h0000_0008);
    wb1_valid = 1'b1; wb1_rd = 5'd3; wb1_data = 32'h0000_0033;
    #1;
    chk("w3_ready1", wb1_ready, 32'h1);
    tick();
    wb1_valid = 1'b0;
    chk("w3_we",   write_enable, 32'h1);
    chk("w3_addr", rd_address,   32'd3);
    #1;
    chk("raw_hazard_still", issue_hazard, 32'h1);
    tick();
    chk("w3_busy_clr",  busy,         32'h0);
    chk("raw_released", issue_hazard, 32'h0);
    tick();
    issue_valid = 1'b0;
    chk("i9_busy", busy, 32'h0000_0200);

    // Drain x9 (wb0 is favoured now because wb1 won last).
    wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h0000_0099;
    tick();
    wb0_valid = 1'b0;
    chk("w9_we",   write_enable, 32'h1);
    chk("w9_addr", rd_address,   32'd9);
    tick();
    chk("w9_busy_clr", busy, 32'h0);

    // A writeback to x0 is consumed but not written.
    wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h1234_5678;
    #1;
    chk("x0_ready1", wb1_ready, 32'h1);
    tick();
    wb1_valid = 1'b0;
    chk("x0_we",   write_enable, 32'h0);
    chk("x0_busy", busy,         32'h0);

    // The x7 write edge coincides with an accepted issue of rd=7, so the set wins.
    wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h0000_0077;
    tick();
    wb0_valid = 1'b0;
    chk("w7_we",        write_enable, 32'h1);
    chk("w7_addr",      rd_address,   32'd7);
    chk("w7_nonbusy",   busy,         32'h0);
    issue_valid = 1'b1; issue_rd = 5'd7; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    #1;
    chk("i7_hazard", issue_hazard, 32'h0);
    tick();
    issue_valid = 1'b0;
    chk("set_wins_busy", busy,         32'h0000_0080);
    chk("set_wins_we",   write_enable, 32'h0);
    wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h0000_0070;
    tick();
    wb1_valid = 1'b0;
    chk("w7b_we", write_enable, 32'h1);
    tick();
    chk("w7b_busy_clr", busy, 32'h0);

    // Reset lands right after a wb0 handshake. The pending write is dropped,
    // busy is cleared, and the pointer returns to wb0.
    issue_valid = 1'b1; issue_rd = 5'd4; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    tick();
    issue_valid = 1'b0;
    chk("i4_busy", busy, 32'h0000_0010);
    wb0_valid = 1'b1; wb0_rd = 5'd4; wb0_data = 32'h0000_0044;
    tick();
    wb0_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mrst_we",   write_enable, 32'h0);
    chk("mrst_busy", busy,         32'h0);
    chk("mrst_addr", rd_address,   32'h0);
    tick();
    chk("mrst_we_hold", write_enable, 32'h0);
    wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'h0000_00C0;
    wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'h0000_00D0;
    #1;
    chk("mrst_ready0", wb0_ready, 32'h0);
    chk("mrst_ready1", wb1_ready, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("post_ready0", wb0_ready, 32'h1);
    chk("post_ready1", wb1_ready, 32'h0);
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    chk("post_we",   write_enable, 32'h1);
    chk("post_addr", rd_address,   32'd1);
    chk("post_data", rd_data,      32'h0000_00C0);
    tick();
    chk("post_we_off", write_enable, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rf_wb_ctrl
`default_nettype wire

// File: doc/rf_wb_ctrl.md
RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, the register data width.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, the reset; asynchronous, active-low.
REQ-004 The block SHALL have port issue_valid, input, 1, an instruction requests issue.
REQ-005 The block SHALL have ports issue_rd, issue_rs1 and issue_rs2, inputs, 5 each, the destination and source register addresses of the issuing instruction.
REQ-006 The block SHALL have port issue_hazard, output, 1, the issue is blocked this cycle.
REQ-007 The block SHALL have ports wb0_valid/wb0_ready/wb0_rd/wb0_data, in/out/in/in, 1/1/5/XLEN, writeback requester 0 (ALU).
REQ-008 The block SHALL have ports wb1_valid/wb1_ready/wb1_rd/wb1_data, in/out/in/in, 1/1/5/XLEN, writeback requester 1 (load unit).
REQ-009 The block SHALL have ports write_enable/rd_address/rd_data, outputs, 1/5/XLEN, which drive the register-file write port.
REQ-010 The block SHALL have port busy, output, 32, the scoreboard with one pending-write bit per register.

Function
REQ-011 The block SHALL assert issue_hazard = issue_valid AND (busy[issue_rs1] OR busy[issue_rs2] OR busy[issue_rd]), combinationally.
REQ-012 An issue SHALL be accepted when issue_valid=1 and issue_hazard=0.
REQ-013 An accepted issue with issue_rd != 0 SHALL set busy[issue_rd] at the clock edge.
REQ-014 busy[0] SHALL be constant 0.
REQ-015 The block SHALL arbitrate the two writeback requesters round-robin, with at most one wbN_ready high per cycle.
REQ-016 wbN_ready SHALL be combinational from the valids and the priority pointer.
REQ-017 A lone valid requester SHALL be granted in the same cycle.
REQ-018 When both requesters are valid, the requester not granted last SHALL win.
REQ-019 The priority pointer SHALL update only on a grant, pointing away from the winner.
REQ-020 A handshake (valid and ready both high) SHALL cause, one cycle later, a single-cycle write_enable=1 with rd_address and rd_data equal to the winner's rd and data.
REQ-021 write_enable SHALL be 0 in every cycle not following a handshake.
REQ-022 A handshake with rd=0 SHALL be consumed but SHALL produce write_enable=0.
REQ-023 busy[rd_address] SHALL clear at the clock edge where write_enable=1, which is the same edge at which the register file commits.
REQ-024 A clear and an accepted issue on the same register at the same edge SHALL leave the bit set (set wins).
REQ-025 A writeback to a non-busy register SHALL still be written, with no scoreboard change.
REQ-026 A requester holding valid without ready SHALL keep its rd and data stable; the block SHALL NOT depend on this for correctness.
REQ-027 Sustained throughput SHALL be one writeback per cycle.

Reset
REQ-028 While reset_n=0, busy SHALL be 0, write_enable 0, rd_address 0 and rd_data 0, with the priority pointer favouring requester 0.
REQ-029 On reset_n deassertion, the first requester granted when both are valid SHALL be wb0.
REQ-030 Reset asserted mid-operation SHALL immediately drop any pending registered write, so that no write_enable pulse follows, and SHALL clear all busy bits.
REQ-031 wbN_ready and issue_hazard SHALL be 0 while reset_n=0.

Structure
REQ-032 The shared package rv_pkg SHALL hold REG_ADDR_W=5, NUM_REGS=32, the XLEN default, and the wb_req_t struct (valid, rd, data).
REQ-033 The two-input round-robin grant logic SHALL be a sub-module named rr_arbiter (inputs req[1:0]; outputs gnt[1:0]; internal pointer).
REQ-034 The scoreboard and output register SHALL reside in rf_wb_ctrl.

Verification
REQ-035 Issue rd=5, then wb0 rd=5 data=0xDEADBEEF -> busy[5]=1 after issue; write_enable=1, rd_address=5, rd_data=0xDEADBEEF one cycle after handshake; busy[5]=0 the following cycle.
REQ-036 busy[3]=1 and issue rs1=3 -> issue_hazard=1, busy unchanged; after the writeback to x3 commits, the same issue is accepted.
REQ-037 wb0 and wb1 both valid for 4 cycles after reset -> grants in order wb0, wb1, wb0, wb1; four consecutive write_enable pulses.
REQ-038 wb1 with rd=0 data=0x12345678 -> wb1_ready=1; write_enable stays 0; busy unchanged.
REQ-039 The write_enable edge for x7 coincides with an accepted issue rd=7 -> busy[7]=1 afterwards.
REQ-040 reset_n pulled low in the cycle after a handshake -> no write_enable pulse; busy=0; first post-reset contention grants wb0.
